point_on_curve_check: RTL and testbench

Sequential validator for short-Weierstrass points with a = 0, checking y² ≡ x³ + b (mod m) and 0 ≤ x, y < m. It sits directly upstream of `point_scalar_mult_c` and gates untrusted (px, py) before they reach the multiplier. It uses the same start/ready level handshake and the same 256-bit operand conventions as the multiplier. Its output can also be chained on the multiplier's (rx, ry) as a result self-check.

---
 rtl/point_on_curve_check.sv | 198 +++++++++++++++++++
 tb/tb_point_on_curve_check.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_on_curve_check.sv
// point_on_curve_check: sequential validator for short-Weierstrass points
// with a = 0. Checks 0 <= x, y < m and y^2 == x^3 + b (mod m) using a
// bit-serial MSB-first interleaved modular multiplier, one multiplier bit
// per cycle. Latency is fixed except for the early range-failure exit.
module point_on_curve_check #(
  parameter int unsigned WIDTH   = 256,
  parameter int unsigned CURVE_B = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] px,
  input  logic [WIDTH-1:0] py,
  input  logic [WIDTH-1:0] m,
  output logic             ready,
  output logic             on_curve,
  output logic             busy
);

  localparam int unsigned      CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] B_CONST = WIDTH'(CURVE_B);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RANGE,
    S_MUL_XX,
    S_MUL_XXX,
    S_ADD_B,
    S_MUL_YY,
    S_CMP,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_on_curve;

  logic             w_last;
  logic             w_range_bad;
  logic             w_bit;
  logic [WIDTH-1:0] w_mcand;
  logic [WIDTH:0]   w_dbl;
  logic             w_dbl_ge;
  logic [WIDTH-1:0] w_dbl_red;
  logic [WIDTH:0]   w_sum;
  logic             w_sum_ge;
  logic [WIDTH-1:0] w_sum_red;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]   w_addb;
  logic             w_addb_ge;
  logic [WIDTH-1:0] w_addb_red;

  assign w_last      = (r_cnt == '0);
  assign w_range_bad = (r_x >= r_m) || (r_y >= r_m);

  // Operand selection for the active multiply: x*x, t*x, y*y.
  always_comb begin
    w_mcand = r_x;
    w_bit   = r_x[r_cnt];
    case (r_state)
      S_MUL_XXX: begin
        w_mcand = r_t;
        w_bit   = r_x[r_cnt];
      end
      S_MUL_YY: begin
        w_mcand = r_y;
        w_bit   = r_y[r_cnt];
      end
      default: begin
        w_mcand = r_x;
        w_bit   = r_x[r_cnt];
      end
    endcase
  end

  // One interleaved step: double and reduce, then conditionally add and
  // reduce. Both partial values stay below 2m, so WIDTH+1 bits suffice and
  // the reduced value fits back into WIDTH bits after a wrapping subtract.
  always_comb begin
    w_dbl      = {r_acc, 1'b0};
    w_dbl_ge   = (w_dbl >= {1'b0, r_m});
    w_dbl_red  = w_dbl_ge ? (w_dbl[WIDTH-1:0] - r_m) : w_dbl[WIDTH-1:0];
    w_sum      = {1'b0, w_dbl_red} + {1'b0, w_mcand};
    w_sum_ge   = (w_sum >= {1'b0, r_m});
    w_sum_red  = w_sum_ge ? (w_sum[WIDTH-1:0] - r_m) : w_sum[WIDTH-1:0];
    w_acc_next = w_bit ? w_sum_red : w_dbl_red;
  end

  // t + b with a single conditional subtract (t < m and b < m).
  always_comb begin
    w_addb     = {1'b0, r_t} + {1'b0, B_CONST};
    w_addb_ge  = (w_addb >= {1'b0, r_m});
    w_addb_red = w_addb_ge ? (w_addb[WIDTH-1:0] - r_m) : w_addb[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state sequencing.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_RANGE;
      S_RANGE:   w_state_next = w_range_bad ? S_DONE : S_MUL_XX;
      S_MUL_XX:  if (w_last) w_state_next = S_MUL_XXX;
      S_MUL_XXX: if (w_last) w_state_next = S_ADD_B;
      S_ADD_B:   w_state_next = S_MUL_YY;
      S_MUL_YY:  if (w_last) w_state_next = S_CMP;
      S_CMP:     w_state_next = S_DONE;
      S_DONE:    if (!start) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, multiply accumulator, results and verdict.
  // Outside the multiply states acc/cnt are held at their entry values, so
  // every multiply starts from acc = 0 at bit WIDTH-1 with no extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_m        <= '0;
      r_t        <= '0;
      r_u        <= '0;
      r_acc      <= '0;
      r_cnt      <= CNT_TOP;
      r_on_curve <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_acc      <= '0;
          r_cnt      <= CNT_TOP;
          r_on_curve <= 1'b0;
          if (start) begin
            r_x <= px;
            r_y <= py;
            r_m <= m;
          end
        end
        S_MUL_XX, S_MUL_XXX, S_MUL_YY: begin
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= CNT_TOP;
            if (r_state == S_MUL_YY) begin
              r_u <= w_acc_next;
            end else begin
              r_t <= w_acc_next;
            end
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_ADD_B: begin
          r_acc <= '0;
          r_cnt <= CNT_TOP;
          r_t   <= w_addb_red;
        end
        S_CMP: begin
          r_acc      <= '0;
          r_cnt      <= CNT_TOP;
          r_on_curve <= (r_t == r_u);
        end
        S_DONE: begin
          r_acc <= '0;
          r_cnt <= CNT_TOP;
          if (!start) begin
            r_on_curve <= 1'b0;
          end
        end
        default: begin
          r_acc <= '0;
          r_cnt <= CNT_TOP;
        end
      endcase
    end
  end

  assign ready    = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign on_curve = r_on_curve;

endmodule

// File: tb/tb_point_on_curve_check.sv
// Testbench for point_on_curve_check: an 8-bit and a 256-bit instance,
// table-driven vectors plus hand-written reset / handshake sequences.
// Expected verdicts come from constants or a wide-arithmetic reference model.
module tb_point_on_curve_check;

  localparam logic [255:0] SECP_P = 256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;
  localparam logic [255:0] GX     = 256'h79be667ef9dcbbac55a06295ce870b07029bfcdb2dce28d959f2815b16f81798;
  localparam logic [255:0] GY     = 256'h483ada7726a3c4655da4fbfc0e1108a8fd17b448a68554199c47d08ffb10d4b8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start8, start256;
  logic [7:0]   px8, py8, m8;
  logic [255:0] px256, py256, m256;
  logic         ready8, on8, busy8;
  logic         ready256, on256, busy256;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit    on;
    int    lat;
    string name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit           wide;
    logic [255:0] x;
    logic [255:0] y;
    logic [255:0] mm;
    bit           exp_on;
    string        name;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  point_on_curve_check #(.WIDTH(8), .CURVE_B(7)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .px       (px8),
    .py       (py8),
    .m        (m8),
    .ready    (ready8),
    .on_curve (on8),
    .busy     (busy8)
  );

  point_on_curve_check #(.WIDTH(256), .CURVE_B(7)) u_dut256 (
    .clk      (clk),
    .rst      (rst),
    .start    (start256),
    .px       (px256),
    .py       (py256),
    .m        (m256),
    .ready    (ready256),
    .on_curve (on256),
    .busy     (busy256)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, independent of the serial algorithm.
  function automatic bit model(input logic [255:0] x, input logic [255:0] y, input logic [255:0] mm);
    logic [511:0] bx, by, bm, t, u;
    if ((x >= mm) || (y >= mm)) return 1'b0;
    bx = {256'd0, x};
    by = {256'd0, y};
    bm = {256'd0, mm};
    t  = (bx * bx) % bm;
    t  = (t * bx) % bm;
    t  = (t + 512'd7) % bm;
    u  = (by * by) % bm;
    return (t == u);
  endfunction

  function automatic logic get_ready(input bit wide);
    return wide ? ready256 : ready8;
  endfunction

  function automatic logic get_on(input bit wide);
    return wide ? on256 : on8;
  endfunction

  function automatic logic get_busy(input bit wide);
    return wide ? busy256 : busy8;
  endfunction

  task automatic set_start(input bit wide, input logic st);
    if (wide) start256 = st;
    else      start8   = st;
  endtask

  task automatic drive(input bit wide, input logic [255:0] x, input logic [255:0] y,
                       input logic [255:0] mm, input logic st);
    if (wide) begin
      px256 = x; py256 = y; m256 = mm; start256 = st;
    end else begin
      px8 = x[7:0]; py8 = y[7:0]; m8 = mm[7:0]; start8 = st;
    end
  endtask

  // One transaction, starting and ending on a negedge with the DUT in IDLE.
  // k counts negedges after the capture edge N, so k is the edge index
  // relative to N at which the sampled value would be seen.
  task automatic run_vec(input bit wide, input logic [255:0] x, input logic [255:0] y,
                         input logic [255:0] mm, input bit exp_on, input string name,
                         input int hold, input int toggle);
    sb_t e;
    int  k;
    bit  got;
    bit  busy_ok;
    bit  hold_ok;
    int  lim;
    e.on   = exp_on;
    e.lat  = ((x >= mm) || (y >= mm)) ? 2 : (wide ? 772 : 28);
    e.name = name;
    lim    = e.lat + 20;
    drive(wide, x, y, mm, 1'b1);
    sb_q.push_back(e);
    k = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && (k < lim)) begin
      @(negedge clk);
      k++;
      if (k == 1) drive(wide, {8{$urandom}}, {8{$urandom}}, {8{$urandom}}, 1'b1);
      if ((toggle != 0) && (k == toggle))     set_start(wide, 1'b0);
      if ((toggle != 0) && (k == toggle + 3)) set_start(wide, 1'b1);
      if (get_ready(wide)) got = 1'b1;
      else if (!get_busy(wide)) busy_ok = 1'b0;
    end
    e = sb_q.pop_front();
    check({e.name, " ready"}, 256'(get_ready(wide)), 256'd1);
    if (got) begin
      check({e.name, " latency"}, 256'(k), 256'(e.lat));
      check({e.name, " on_curve"}, 256'(get_on(wide)), 256'(e.on));
      check({e.name, " busy during run"}, 256'(busy_ok), 256'd1);
      check({e.name, " busy at ready"}, 256'(get_busy(wide)), 256'd0);
    end
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!get_ready(wide) || (get_on(wide) !== e.on) || get_busy(wide)) hold_ok = 1'b0;
    end
    if (hold > 0) check({e.name, " hold"}, 256'(hold_ok), 256'd1);
    set_start(wide, 1'b0);
    @(negedge clk);
    check({e.name, " release ready"}, 256'(get_ready(wide)), 256'd0);
    check({e.name, " release on_curve"}, 256'(get_on(wide)), 256'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] gy_flip, gy_neg, pm1;
    logic [255:0] rm, rx, ry;
    int unsigned  mi;
    bit           found;
    int           k;

    rst = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset w8 ready/busy/on", 256'({ready8, busy8, on8}), 256'd0);
    check("reset w256 ready/busy/on", 256'({ready256, busy256, on256}), 256'd0);
    rst = 1'b0;
    @(negedge clk);

    gy_flip = GY ^ 256'd1;
    gy_neg  = SECP_P - GY;
    pm1     = SECP_P - 256'd1;

    vecs.push_back('{1'b0, 256'd1,  256'd10, 256'd23, 1'b1, "w8 (1,10)"});
    vecs.push_back('{1'b0, 256'd1,  256'd11, 256'd23, 1'b0, "w8 (1,11)"});
    vecs.push_back('{1'b0, 256'd23, 256'd10, 256'd23, 1'b0, "w8 px=m"});
    vecs.push_back('{1'b0, 256'd1,  256'd23, 256'd23, 1'b0, "w8 py=m"});
    vecs.push_back('{1'b0, 256'd22, 256'd22, 256'd23, 1'b0, "w8 (m-1,m-1)"});
    vecs.push_back('{1'b0, 256'd0,  256'd0,  256'd0,  1'b0, "w8 m=0"});
    vecs.push_back('{1'b1, GX,      GY,      SECP_P,  1'b1, "w256 G"});
    vecs.push_back('{1'b1, GX,      gy_flip, SECP_P,  1'b0, "w256 G.y^1"});
    vecs.push_back('{1'b1, GX,      gy_neg,  SECP_P,  1'b1, "w256 -G"});
    vecs.push_back('{1'b1, SECP_P,  GY,      SECP_P,  1'b0, "w256 px=m"});
    vecs.push_back('{1'b1, GX,      pm1,     SECP_P,  1'b0, "w256 py=m-1"});
    vecs.push_back('{1'b1, 256'd1,  256'd10, 256'd23, 1'b1, "w256 small m"});

    foreach (vecs[i]) begin
      run_vec(vecs[i].wide, vecs[i].x, vecs[i].y, vecs[i].mm, vecs[i].exp_on, vecs[i].name, 0, 0);
    end

    // Random 8-bit points; the first half searched to land on the curve.
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       mi = 23;
        1:       mi = 97;
        default: mi = 251;
      endcase
      rm = 256'(mi);
      rx = 256'($urandom_range(mi));
      ry = 256'($urandom_range(mi));
      if (i < 6) begin
        found = 1'b0;
        for (int j = 0; j < int'(mi); j++) begin
          if (!found && model(rx, 256'(j), rm)) begin
            ry = 256'(j);
            found = 1'b1;
          end
        end
      end
      run_vec(1'b0, rx, ry, rm, model(rx, ry, rm), "w8 random", 0, 0);
    end

    // Reset in the middle of MUL_XXX.
    drive(1'b1, GX, GY, SECP_P, 1'b1);
    k = 0;
    repeat (300) begin
      @(negedge clk);
      k++;
    end
    check("pre-reset busy", 256'(busy256), 256'd1);
    rst = 1'b1;
    start256 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid-run reset ready", 256'(ready256), 256'd0);
    check("mid-run reset busy", 256'(busy256), 256'd0);
    check("mid-run reset on_curve", 256'(on256), 256'd0);
    run_vec(1'b1, GX, GY, SECP_P, 1'b1, "w256 G after reset", 0, 0);

    // Reset while DONE reports a valid point.
    drive(1'b0, 256'd1, 256'd10, 256'd23, 1'b1);
    k = 0;
    while (!ready8 && (k < 60)) begin
      @(negedge clk);
      k++;
    end
    check("done before reset on_curve", 256'(on8), 256'd1);
    rst = 1'b1;
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("done reset ready", 256'(ready8), 256'd0);
    check("done reset on_curve", 256'(on8), 256'd0);
    @(negedge clk);

    // Hold start through DONE, then a second run at the same latency.
    run_vec(1'b1, GX, GY, SECP_P, 1'b1, "w256 hold 50", 50, 0);
    run_vec(1'b1, GX, GY, SECP_P, 1'b1, "w256 second run", 0, 0);
    run_vec(1'b0, 256'd1, 256'd10, 256'd23, 1'b1, "w8 hold 50", 50, 0);

    // start dropped and re-raised mid-run is ignored.
    run_vec(1'b1, GX, gy_neg, SECP_P, 1'b1, "w256 start toggle", 0, 100);
    run_vec(1'b0, 256'd1, 256'd11, 256'd23, 1'b0, "w8 start toggle", 0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
